controller: RTL and testbench



---
 rtl/controller_if.sv | 38 +++
 rtl/controller.sv | 176 +++++++++++++++++
 tb/tb_controller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/controller_if.sv
// Control bus between the accumulator-CPU controller and its datapath.
// The master modport is the controller side; the slave modport is the
// datapath side, which supplies the opcode fields and flags and receives
// every strobe, select and debug output.
interface controller_if;
    logic [4:0] opCode;
    logic       D;
    logic       CF;
    logic       ZF;
    logic       Reset_out;
    logic [3:0] Current_state_test;
    logic       ALU_MUX;
    logic [3:0] ALU_OP;
    logic       PC_INC;
    logic       PC_LOAD;
    logic       IR_WR_CLK;
    logic       RAM_WR;
    logic       RAM_RD;
    logic       FLAG_WR_CLK;
    logic       RAM_MUX;
    logic       MDR_WR_CLK;
    logic       A_WR_CLK;
    logic       ALU_EN;

    modport master (
        input  opCode, D, CF, ZF,
        output Reset_out, Current_state_test, ALU_MUX, ALU_OP, PC_INC, PC_LOAD,
               IR_WR_CLK, RAM_WR, RAM_RD, FLAG_WR_CLK, RAM_MUX, MDR_WR_CLK,
               A_WR_CLK, ALU_EN
    );

    modport slave (
        output opCode, D, CF, ZF,
        input  Reset_out, Current_state_test, ALU_MUX, ALU_OP, PC_INC, PC_LOAD,
               IR_WR_CLK, RAM_WR, RAM_RD, FLAG_WR_CLK, RAM_MUX, MDR_WR_CLK,
               A_WR_CLK, ALU_EN
    );
endinterface

// File: rtl/controller.sv
// Multi-cycle Moore control unit for the accumulator CPU.
// Sequences fetch / decode / execute and decodes opcode, D and flags into
// datapath strobes. All outputs are combinational from state, opCode and D.
// Optional macro CONTROLLER_STATE_DBG_EN exposes the state register on
// Current_state_test; otherwise that port is tied to zero.
module controller (
    input  logic          CLK,
    input  logic          Reset_in,
    controller_if.master  bus
);
    localparam logic [3:0] ST_RESET     = 4'd0;
    localparam logic [3:0] ST_FETCH     = 4'd1;
    localparam logic [3:0] ST_DECODE    = 4'd2;
    localparam logic [3:0] ST_EXEC_A    = 4'd3;
    localparam logic [3:0] ST_EXEC_B    = 4'd4;
    localparam logic [3:0] ST_JUMP      = 4'd5;
    localparam logic [3:0] ST_IND_RD    = 4'd6;
    localparam logic [3:0] ST_IND_SETUP = 4'd7;
    localparam logic [3:0] ST_IND_WR    = 4'd8;

    // Power-up value puts the machine in RESET without Reset_in.
    logic [3:0] state_q = ST_RESET;
    logic [3:0] state_d;

    logic grp_a, grp_b, grp_c, grp_d, grp_e;
    logic alu_mux_dec;
    logic jump_take;

    // Opcode decode into instruction groups, B-operand select and jump condition.
    always_comb begin
        grp_a       = 1'b0;
        grp_b       = 1'b0;
        grp_c       = 1'b0;
        grp_d       = 1'b0;
        grp_e       = 1'b0;
        alu_mux_dec = 1'b0;
        jump_take   = 1'b0;
        case (bus.opCode)
            5'b00000: grp_a = 1'b1;
            5'b00001: begin grp_a = 1'b1; alu_mux_dec = 1'b1; end
            5'b00010: grp_b = 1'b1;
            5'b00011: grp_d = 1'b1;
            5'b00100: grp_e = 1'b1;
            5'b00101, 5'b00110, 5'b00111: grp_a = 1'b1;
            5'b01000, 5'b01001, 5'b01010, 5'b01011,
            5'b01100, 5'b01101, 5'b01110, 5'b01111: begin
                alu_mux_dec = 1'b1;
                grp_a       = ~bus.D;
                grp_b       = bus.D;
            end
            5'b10100: begin grp_c = 1'b1; jump_take = 1'b1;     end
            5'b10101: begin grp_c = 1'b1; jump_take = bus.CF;   end
            5'b10110: begin grp_c = 1'b1; jump_take = bus.ZF;   end
            5'b10111: begin grp_c = 1'b1; jump_take = ~bus.CF;  end
            5'b11000: begin grp_c = 1'b1; jump_take = ~bus.ZF;  end
            default: ;
        endcase
    end

    // Next-state logic; illegal codes recover to FETCH.
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_RESET:  state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                if (grp_a)              state_d = ST_EXEC_A;
                else if (grp_b)         state_d = ST_EXEC_B;
                else if (grp_c)         state_d = jump_take ? ST_JUMP : ST_FETCH;
                else if (grp_d | grp_e) state_d = ST_IND_RD;
                else                    state_d = ST_FETCH;
            end
            ST_IND_RD: begin
                if (grp_d)      state_d = ST_EXEC_A;
                else if (grp_e) state_d = ST_IND_SETUP;
                else            state_d = ST_FETCH;
            end
            ST_IND_SETUP: state_d = ST_IND_WR;
            default:      state_d = ST_FETCH;
        endcase
    end

    // State register with synchronous reset that overrides any instruction in flight.
    always_ff @(posedge CLK) begin
        if (Reset_in) state_q <= ST_RESET;
        else          state_q <= state_d;
    end

    logic       reset_out;
    logic       alu_mux;
    logic [3:0] alu_op;
    logic       pc_inc, pc_load, ir_wr, ram_wr, ram_rd, flag_wr;
    logic       ram_mux, mdr_wr, a_wr, alu_en;

    // Moore output decode; anything not named for a state stays low.
    always_comb begin
        reset_out = 1'b0;
        alu_mux   = 1'b0;
        alu_op    = 4'd0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        ir_wr     = 1'b0;
        ram_wr    = 1'b0;
        ram_rd    = 1'b0;
        flag_wr   = 1'b0;
        ram_mux   = 1'b0;
        mdr_wr    = 1'b0;
        a_wr      = 1'b0;
        alu_en    = 1'b0;
        case (state_q)
            ST_RESET: reset_out = 1'b1;
            ST_FETCH: begin
                ram_rd = 1'b1;
                ir_wr  = 1'b1;
                pc_inc = 1'b1;
            end
            ST_DECODE: mdr_wr = 1'b1;
            ST_EXEC_A: begin
                ram_rd  = 1'b1;
                ram_mux = 1'b1;
                alu_en  = 1'b1;
                a_wr    = 1'b1;
                alu_mux = alu_mux_dec;
                alu_op  = bus.opCode[3:0];
                // Flags only for the literal and memory ALU opcodes 00101..01111.
                flag_wr = (bus.opCode[4:3] == 2'b01) ||
                          (bus.opCode[4:3] == 2'b00 && bus.opCode[2:0] >= 3'd5);
            end
            ST_EXEC_B: begin
                alu_en  = 1'b1;
                ram_wr  = 1'b1;
                ram_mux = 1'b1;
                alu_op  = bus.opCode[3:0];
                flag_wr = (bus.opCode != 5'b00010);
            end
            ST_JUMP: pc_load = 1'b1;
            ST_IND_RD: begin
                ram_rd  = 1'b1;
                ram_mux = 1'b1;
                mdr_wr  = 1'b1;
            end
            ST_IND_SETUP: begin
                alu_en  = 1'b1;
                ram_mux = 1'b1;
                alu_op  = bus.opCode[3:0];
            end
            ST_IND_WR: begin
                alu_en  = 1'b1;
                ram_wr  = 1'b1;
                ram_mux = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.Reset_out   = reset_out;
    assign bus.ALU_MUX     = alu_mux;
    assign bus.ALU_OP      = alu_op;
    assign bus.PC_INC      = pc_inc;
    assign bus.PC_LOAD     = pc_load;
    assign bus.IR_WR_CLK   = ir_wr;
    assign bus.RAM_WR      = ram_wr;
    assign bus.RAM_RD      = ram_rd;
    assign bus.FLAG_WR_CLK = flag_wr;
    assign bus.RAM_MUX     = ram_mux;
    assign bus.MDR_WR_CLK  = mdr_wr;
    assign bus.A_WR_CLK    = a_wr;
    assign bus.ALU_EN      = alu_en;

`ifdef CONTROLLER_STATE_DBG_EN
    assign bus.Current_state_test = state_q;
`else
    assign bus.Current_state_test = 4'b0000;
`endif

endmodule

// File: tb/tb_controller.sv
// Directed bench for the controller: each instruction pushes its expected
// state sequence into a queue; every cycle one entry is popped and the full
// output vector is compared against a reference decode of that state.
module tb_controller;
    logic CLK = 1'b0;
    logic Reset_in = 1'b0;
    controller_if bus ();

    controller dut (
        .CLK      (CLK),
        .Reset_in (Reset_in),
        .bus      (bus)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    // Reference output vector:
    // {Reset_out, ALU_MUX, ALU_OP[3:0], PC_INC, PC_LOAD, IR_WR, RAM_WR, RAM_RD,
    //  FLAG_WR, RAM_MUX, MDR_WR, A_WR, ALU_EN}
    function automatic logic [15:0] ref_outs(input logic [3:0] st, input logic [4:0] op, input logic d);
        logic rst_o, amux, pinc, pload, irw, rw, rr, fw, rmux, mw, aw, aen;
        logic [3:0] aop;
        int opi;
        opi = int'(op);
        {rst_o, amux, pinc, pload, irw, rw, rr, fw, rmux, mw, aw, aen} = '0;
        aop = (st == 4'd3 || st == 4'd4 || st == 4'd7) ? op[3:0] : 4'd0;
        case (st)
            4'd0: rst_o = 1'b1;
            4'd1: begin rr = 1; irw = 1; pinc = 1; end
            4'd2: mw = 1;
            4'd3: begin
                rr = 1; rmux = 1; aen = 1; aw = 1;
                amux = (opi == 1) || (opi >= 8 && opi <= 15);
                fw   = (opi >= 5 && opi <= 15);
            end
            4'd4: begin aen = 1; rw = 1; rmux = 1; fw = (opi != 2); end
            4'd5: pload = 1;
            4'd6: begin rr = 1; rmux = 1; mw = 1; end
            4'd7: begin aen = 1; rmux = 1; end
            4'd8: begin aen = 1; rw = 1; rmux = 1; end
            default: ;
        endcase
        if (d === 1'bx) rst_o = 1'bx;
        return {rst_o, amux, aop, pinc, pload, irw, rw, rr, fw, rmux, mw, aw, aen};
    endfunction

    function automatic logic [15:0] dut_outs();
        return {bus.Reset_out, bus.ALU_MUX, bus.ALU_OP, bus.PC_INC, bus.PC_LOAD,
                bus.IR_WR_CLK, bus.RAM_WR, bus.RAM_RD, bus.FLAG_WR_CLK, bus.RAM_MUX,
                bus.MDR_WR_CLK, bus.A_WR_CLK, bus.ALU_EN};
    endfunction

    // Compare one cycle against the oldest expected state, then advance a clock.
    task automatic check_cycle(input string tag, input logic rst_next);
        logic [3:0]  st;
        logic [15:0] exp_v, got_v;
        logic [3:0]  exp_dbg;
        checks++;
        assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed state_dbg=%0d required an expected entry", tag, bus.Current_state_test);
        end
        if (exp_q.size() > 0) begin
            st    = exp_q.pop_front();
            exp_v = ref_outs(st, bus.opCode, bus.D);
            got_v = dut_outs();
            checks++;
            assert (got_v === exp_v) else begin
                errors++;
                $error("FAIL %s outs st=%0d: observed=%016b expected=%016b", tag, st, got_v, exp_v);
            end
`ifdef CONTROLLER_STATE_DBG_EN
            exp_dbg = st;
`else
            exp_dbg = 4'b0000;
`endif
            checks++;
            assert (bus.Current_state_test === exp_dbg) else begin
                errors++;
                $error("FAIL %s dbg st=%0d: observed=%0d expected=%0d", tag, st, bus.Current_state_test, exp_dbg);
            end
            checks++;
            assert (!(bus.RAM_WR === 1'b1 && bus.RAM_RD === 1'b1)) else begin
                errors++;
                $error("FAIL %s rdwr st=%0d: observed RAM_WR=%b RAM_RD=%b expected not both", tag, st, bus.RAM_WR, bus.RAM_RD);
            end
            checks++;
            assert (bus.PC_INC === (st == 4'd1)) else begin
                errors++;
                $error("FAIL %s pcinc st=%0d: observed=%b expected=%b", tag, st, bus.PC_INC, (st == 4'd1));
            end
            $display("cycle %s op=%05b D=%b CF=%b ZF=%b st=%0d outs=%016b", tag, bus.opCode, bus.D, bus.CF, bus.ZF, st, got_v);
        end
        Reset_in = rst_next;
        @(posedge CLK);
        #1;
    endtask

    // One instruction: seq holds up to five state nibbles, first in the MSBs.
    task automatic instr(input string tag, input logic [4:0] op, input logic d, input logic cf,
                         input logic zf, input int n, input logic [19:0] seq);
        bus.opCode = op;
        bus.D      = d;
        bus.CF     = cf;
        bus.ZF     = zf;
        for (int i = 0; i < n; i++) exp_q.push_back(seq[19 - 4*i -: 4]);
        for (int i = 0; i < n; i++) check_cycle(tag, 1'b0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.opCode = 5'b00000;
        bus.D      = 1'b0;
        bus.CF     = 1'b0;
        bus.ZF     = 1'b0;
        #1;
        // Power-up with no reset asserted starts in RESET.
        exp_q.push_back(4'd0);
        check_cycle("powerup", 1'b0);
        instr("MOVLA",     5'b00000, 0, 0, 0, 3, 20'h12300);
        instr("ALUm_D0",   5'b01101, 0, 0, 0, 3, 20'h12300);
        instr("ALUm_D1",   5'b01101, 1, 0, 0, 3, 20'h12400);
        instr("ALUlit",    5'b00101, 0, 0, 0, 3, 20'h12300);
        instr("MOVRA",     5'b00001, 1, 0, 0, 3, 20'h12300);
        instr("MOVAR",     5'b00010, 1, 0, 0, 3, 20'h12400);
        instr("JZ_t",      5'b10110, 0, 0, 1, 3, 20'h12500);
        instr("JZ_nt",     5'b10110, 0, 0, 0, 2, 20'h12000);
        instr("JC_t",      5'b10101, 0, 1, 0, 3, 20'h12500);
        instr("JNC_nt",    5'b10111, 0, 1, 0, 2, 20'h12000);
        instr("JNZ_t",     5'b11000, 0, 0, 0, 3, 20'h12500);
        instr("JMP",       5'b10100, 0, 0, 0, 3, 20'h12500);
        instr("MOVIRA",    5'b00011, 0, 0, 0, 4, 20'h12630);
        instr("MOVIAR",    5'b00100, 0, 0, 0, 5, 20'h12678);
        instr("NOP1f",     5'b11111, 0, 1, 1, 2, 20'h12000);
        instr("NOP10",     5'b10000, 1, 0, 0, 2, 20'h12000);

        // Reset pulse during IND_SETUP aborts MOVIAR before any RAM write.
        bus.opCode = 5'b00100;
        bus.D      = 1'b0;
        exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd6);
        exp_q.push_back(4'd7); exp_q.push_back(4'd0);
        check_cycle("rstmid", 1'b0);
        check_cycle("rstmid", 1'b0);
        check_cycle("rstmid", 1'b0);
        check_cycle("rstmid", 1'b1);
        check_cycle("rstmid", 1'b0);
        instr("afterrst",  5'b11111, 0, 0, 0, 2, 20'h12000);

        // Reset held two edges keeps the state in RESET.
        bus.opCode = 5'b01101;
        bus.D      = 1'b1;
        exp_q.push_back(4'd1); exp_q.push_back(4'd0); exp_q.push_back(4'd0);
        check_cycle("rsthold", 1'b1);
        check_cycle("rsthold", 1'b1);
        check_cycle("rsthold", 1'b0);
        instr("final",     5'b01101, 1, 0, 0, 3, 20'h12400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
